// File: rtl/adc_channel_sequencer.sv
// Round-robin ADC channel scheduler: settles the mux, strobes 2^POWER conversions per visit,
// and emits one averaged, channel-tagged result per visit. Optional watchdog: ADC_SEQ_TIMEOUT_EN.
module adc_channel_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int CH_W           = 2,
  parameter int POWER          = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic [CH_W-1:0]   adc_channel,
  output logic              adc_convst,
  input  logic              adc_ready,
  input  logic [15:0]       adc_data,
  output logic              result_valid,
  output logic [CH_W-1:0]   result_channel,
  output logic [15:0]       result_data,
  output logic              busy,
`ifdef ADC_SEQ_TIMEOUT_EN
  output logic              timeout_err,
`endif
  output logic [2:0]        dbg_state
);

  localparam int SAMPLES = 1 << POWER;
  localparam int ACC_W   = 16 + POWER;
  localparam int CNT_W   = POWER + 1;
  localparam int SET_W   = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'(SAMPLES - 1);
  localparam logic [SET_W-1:0] LAST_SETTLE = SET_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETTLE = 3'd1,
    S_CONVST = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t           state, state_next;
  logic             ready_r, ready_pulse;
  logic [ACC_W-1:0] acc, acc_sum;
  logic [CNT_W-1:0] sample_cnt;
  logic [SET_W-1:0] settle_cnt;
  logic [CH_W-1:0]  last_ch, base_ch, sel_ch, sel_after, wrap_ch;
  logic             found_after, can_run;
  logic             load_ch, take_sample, end_visit;

`ifdef ADC_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] LAST_WD = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_cnt;
  logic            timeout_hit;
`endif

  // Handshake: adc_convst is a one-cycle strobe; a conversion is complete on the first
  // cycle adc_ready is seen high after being low, and adc_data is valid in that cycle.
  // Edges arriving outside WAIT are dropped.
  assign ready_pulse = adc_ready & ~ready_r;
  assign acc_sum     = acc + ACC_W'(adc_data);
  assign can_run     = enable & (|ch_mask);
  assign dbg_state   = state;

  // Outside IDLE the outgoing channel is the reference point for the next pick.
  assign base_ch = (state == S_IDLE) ? last_ch : adc_channel;

  always_comb begin
    sel_after   = '0;
    wrap_ch     = '0;
    found_after = 1'b0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (ch_mask[i]) begin
        wrap_ch = CH_W'(i);
        if (i > int'(base_ch)) begin
          sel_after   = CH_W'(i);
          found_after = 1'b1;
        end
      end
    end
    sel_ch = found_after ? sel_after : wrap_ch;
  end

  always_comb begin
    state_next  = state;
    load_ch     = 1'b0;
    take_sample = 1'b0;
    end_visit   = 1'b0;
`ifdef ADC_SEQ_TIMEOUT_EN
    timeout_hit = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        if (can_run) begin
          state_next = S_SETTLE;
          load_ch    = 1'b1;
        end
      end
      S_SETTLE: if (settle_cnt == LAST_SETTLE) state_next = S_CONVST;
      S_CONVST: state_next = S_WAIT;
      S_WAIT: begin
        if (ready_pulse) begin
          take_sample = 1'b1;
          state_next  = (sample_cnt == LAST_SAMPLE) ? S_DONE : S_CONVST;
        end
`ifdef ADC_SEQ_TIMEOUT_EN
        else if (wd_cnt == LAST_WD) begin
          timeout_hit = 1'b1;
          end_visit   = 1'b1;
          load_ch     = can_run;
          state_next  = can_run ? S_SETTLE : S_IDLE;
        end
`endif
      end
      S_DONE: begin
        end_visit  = 1'b1;
        load_ch    = can_run;
        state_next = can_run ? S_SETTLE : S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ready_r        <= 1'b0;
      adc_channel    <= '0;
      adc_convst     <= 1'b0;
      busy           <= 1'b0;
      result_valid   <= 1'b0;
      result_channel <= '0;
      result_data    <= '0;
      acc            <= '0;
      sample_cnt     <= '0;
      settle_cnt     <= '0;
      last_ch        <= CH_W'(NUM_CH - 1);
`ifdef ADC_SEQ_TIMEOUT_EN
      wd_cnt         <= '0;
      timeout_err    <= 1'b0;
`endif
    end else begin
      ready_r      <= adc_ready;
      adc_convst   <= (state_next == S_CONVST);
      busy         <= (state_next != S_IDLE);
      result_valid <= 1'b0;
      if (load_ch) begin
        adc_channel <= sel_ch;
        settle_cnt  <= '0;
      end else if (state == S_SETTLE) begin
        settle_cnt <= settle_cnt + 1'b1;
      end
      if (take_sample) begin
        acc        <= acc_sum;
        sample_cnt <= sample_cnt + 1'b1;
        if (state_next == S_DONE) begin
          result_valid   <= 1'b1;
          result_channel <= adc_channel;
          result_data    <= acc_sum[POWER +: 16];
        end
      end
      if (end_visit) begin
        acc        <= '0;
        sample_cnt <= '0;
        last_ch    <= adc_channel;
      end
`ifdef ADC_SEQ_TIMEOUT_EN
      if (state == S_CONVST)    wd_cnt <= '0;
      else if (state == S_WAIT) wd_cnt <= wd_cnt + 1'b1;
      if (timeout_hit) timeout_err <= 1'b1;
`endif
    end
  end

endmodule
